// File: rtl/grn_node_dual_traj.sv
// Gene-regulatory-network node with slow (s0) and fast (s1) trajectory copies
// for tortoise/hare attractor detection.
module grn_node_dual_traj #(
  parameter int STATE_W  = 1,
  parameter int SLOW_DIV = 2,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reset_nos,
  input  logic [STATE_W-1:0] init_state,
  input  logic               start_s0,
  input  logic               start_s1,
  input  logic [STATE_W-1:0] next_s0,
  input  logic [STATE_W-1:0] next_s1,
  output logic [STATE_W-1:0] s0,
  output logic [STATE_W-1:0] s1,
  output logic               s0_upd,
  output logic               s1_upd,
  output logic               match,
  output logic [CNT_W-1:0]   chg_cnt
);

  localparam int DIV_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SLOW_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             s0_fire;
  logic             s1_count;

  // With SLOW_DIV == 1 the reload value is 0, so every start_s0 fires.
  assign s0_fire  = start_s0 && (div_cnt == '0);
  assign s1_count = start_s1 && (next_s1 != s1) && (chg_cnt != '1);
  assign match    = (s0 == s1);

  // NOTE: every register, including the divider, sits under the synchronous
  // reset so no X ever reaches the neighbour regulation functions; all state
  // updates use non-blocking assignments so the edge samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0      <= '0;
      s1      <= '0;
      s0_upd  <= 1'b0;
      s1_upd  <= 1'b0;
      chg_cnt <= '0;
      div_cnt <= DIV_LOAD;
    end else if (reset_nos) begin
      s0      <= init_state;
      s1      <= init_state;
      s0_upd  <= 1'b0;
      s1_upd  <= 1'b0;
      chg_cnt <= '0;
      div_cnt <= '0;
    end else begin
      s0_upd <= s0_fire;
      s1_upd <= start_s1;
      if (s0_fire) begin
        s0      <= next_s0;
        div_cnt <= DIV_LOAD;
      end else if (start_s0) begin
        div_cnt <= div_cnt - DIV_W'(1);
      end
      if (start_s1) s1 <= next_s1;
      if (s1_count) chg_cnt <= chg_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_grn_node_dual_traj.sv
// Scoreboard bench for grn_node_dual_traj: two instances (3-bit/div3/cnt2 and
// 1-bit/div2/cnt16) driven by shared control, checked against a pulse-index model.
module tb_grn_node_dual_traj;

  typedef struct {
    int s0;
    int s1;
    int k;          // start_s0 pulses since last rst/reset_nos
    bit after_nos;  // last re-init was reset_nos (else rst)
    int changes;    // unsaturated count of value-changing s1 updates
    bit u0;
    bit u1;
  } mdl_t;

  typedef struct {
    mdl_t a;
    mdl_t b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, reset_nos = 1'b0, start_s0 = 1'b0, start_s1 = 1'b0;
  logic [2:0] init_a = '0, n0_a = '0, n1_a = '0;
  logic       init_b = 1'b0, n0_b = 1'b0, n1_b = 1'b0;

  logic [2:0]  a_s0, a_s1;
  logic        a_u0, a_u1, a_match;
  logic [1:0]  a_cnt;
  logic        b_s0, b_s1, b_u0, b_u1, b_match;
  logic [15:0] b_cnt;

  grn_node_dual_traj #(.STATE_W(3), .SLOW_DIV(3), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_a),
    .start_s0(start_s0), .start_s1(start_s1), .next_s0(n0_a), .next_s1(n1_a),
    .s0(a_s0), .s1(a_s1), .s0_upd(a_u0), .s1_upd(a_u1), .match(a_match),
    .chg_cnt(a_cnt)
  );

  grn_node_dual_traj #(.STATE_W(1), .SLOW_DIV(2), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_b),
    .start_s0(start_s0), .start_s1(start_s1), .next_s0(n0_b), .next_s1(n1_b),
    .s0(b_s0), .s1(b_s1), .s0_upd(b_u0), .s1_upd(b_u1), .match(b_match),
    .chg_cnt(b_cnt)
  );

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  mdl_t ma, mb;

  // After rst the divider skips SLOW_DIV-1 pulses first; after reset_nos it
  // fires on the first pulse. Expressed here as a pulse index modulo div.
  function automatic mdl_t step(mdl_t m, bit r, bit nos, bit st0, bit st1,
                                int init, int nx0, int nx1, int div);
    mdl_t n = m;
    bit   fire;
    if (r) begin
      n = '{s0: 0, s1: 0, k: 0, after_nos: 1'b0, changes: 0, u0: 1'b0, u1: 1'b0};
    end else if (nos) begin
      n = '{s0: init, s1: init, k: 0, after_nos: 1'b1, changes: 0, u0: 1'b0, u1: 1'b0};
    end else begin
      n.u0 = 1'b0;
      if (st0) begin
        fire = m.after_nos ? (m.k % div == 0) : (m.k % div == div - 1);
        n.k  = m.k + 1;
        if (fire) begin
          n.s0 = nx0;
          n.u0 = 1'b1;
        end
      end
      n.u1 = st1;
      if (st1) begin
        if (nx1 != m.s1) n.changes = m.changes + 1;
        n.s1 = nx1;
      end
    end
    return n;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic cmp_node(string tag, logic [31:0] s0, logic [31:0] s1,
                          logic [31:0] u0, logic [31:0] u1, logic [31:0] m,
                          logic [31:0] cnt, mdl_t x, int cmax);
    check({tag, "_s0"}, s0, x.s0);
    check({tag, "_s1"}, s1, x.s1);
    check({tag, "_s0_upd"}, u0, 32'(x.u0));
    check({tag, "_s1_upd"}, u1, 32'(x.u1));
    check({tag, "_match"}, m, (x.s0 == x.s1) ? 32'd1 : 32'd0);
    check({tag, "_chg_cnt"}, cnt, (x.changes > cmax) ? cmax : x.changes);
  endtask

  // Monitor: one expected response per driven cycle, sampled after the edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp_node("a", 32'(a_s0), 32'(a_s1), 32'(a_u0), 32'(a_u1), 32'(a_match),
               32'(a_cnt), e.a, 3);
      cmp_node("b", 32'(b_s0), 32'(b_s1), 32'(b_u0), 32'(b_u1), 32'(b_match),
               32'(b_cnt), e.b, 65535);
    end
  end

  task automatic drive(bit r, bit nos, bit st0, bit st1,
                       int ia, int xa0, int xa1, int ib, int xb0, int xb1);
    @(negedge clk);
    rst       = r;
    reset_nos = nos;
    start_s0  = st0;
    start_s1  = st1;
    init_a    = 3'(ia);
    n0_a      = 3'(xa0);
    n1_a      = 3'(xa1);
    init_b    = 1'(ib);
    n0_b      = 1'(xb0);
    n1_b      = 1'(xb1);
    ma = step(ma, r, nos, st0, st1, ia & 7, xa0 & 7, xa1 & 7, 3);
    mb = step(mb, r, nos, st0, st1, ib & 1, xb0 & 1, xb1 & 1, 2);
    q.push_back('{a: ma, b: mb});
  endtask

  function automatic int rnd3();
    return int'($urandom_range(0, 7));
  endfunction

  initial begin
    int seq[6] = '{2, 3, 4, 6, 7, 1};
    int w;
    ma = '{s0: 0, s1: 0, k: 0, after_nos: 1'b0, changes: 0, u0: 1'b0, u1: 1'b0};
    mb = ma;

    // Reset, then divided slow-copy stepping from the post-rst phase.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 1, 0, 7, 7, 0, 1, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, rnd3(), 0, 0, 1, 0);

    // Network re-init, then divided stepping from the post-reset_nos phase.
    drive(0, 1, 0, 0, 5, 0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 0, 0, seq[i], 0, 0, i & 1, 0);

    // reset_nos wins over starts asserted in the same cycle.
    drive(0, 1, 1, 1, 4, 7, 7, 0, 1, 1);

    // Change counter saturation, then an update that does not change s1.
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 0, ma.s1 ^ 1, 0, 0, mb.s1 ^ 1);
    drive(0, 0, 0, 1, 0, 0, ma.s1, 0, 0, mb.s1);

    // Tortoise/hare on a 1-bit oscillator, with rst mid-run.
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      drive(0, 0, 1, 1, 0, rnd3(), rnd3(), 0, mb.s0 ^ 1, mb.s1 ^ 1);
    drive(1, 0, 1, 1, 0, rnd3(), rnd3(), 0, 1, 1);
    for (int i = 0; i < 8; i++)
      drive(0, 0, 1, 1, 0, rnd3(), rnd3(), 0, mb.s0 ^ 1, mb.s1 ^ 1);

    // Randomized traffic with occasional re-initialisation.
    for (int i = 0; i < 400; i++)
      drive(($urandom % 50) == 0, ($urandom % 30) == 0, $urandom % 2, $urandom % 2,
            rnd3(), rnd3(), rnd3(), $urandom % 2, $urandom % 2, $urandom % 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    w = 0;
    while (q.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
